// File: rtl/fb_arbiter.sv
// fb_arbiter: shares the single-pixel framebuffer port between scanout
// (port 0, high priority) and the drawing engine (port 1).
module fb_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] p0_x,
  input  logic [7:0] p0_y,
  input  logic       p0_rd,
  input  logic       p0_wr,
  input  logic       p0_in,
  output logic       p0_ack,
  output logic       p0_out,
  output logic       p0_err,
  input  logic [8:0] p1_x,
  input  logic [7:0] p1_y,
  input  logic       p1_rd,
  input  logic       p1_wr,
  input  logic       p1_in,
  output logic       p1_ack,
  output logic       p1_out,
  output logic       p1_err,
  output logic [8:0] x_b,
  output logic [7:0] y_b,
  output logic       read_b,
  output logic       write_b,
  output logic       in_b,
  input  logic       out_b,
  input  logic       rdy_b,
  output logic [1:0] grant,
  output logic       busy
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic [1:0]    pend;
  logic [1:0]    swr;
  logic [1:0]    sin;
  logic [1:0][8:0] sx;
  logic [1:0][7:0] sy;
  logic          owner;
  logic [SW-1:0] streak;
  logic [CW-1:0] cnt;

  logic [1:0][8:0] px;
  logic [1:0][7:0] py;
  logic [1:0]    pwr;
  logic [1:0]    pin;
  logic [1:0]    req;
  logic [1:0]    clr;
  logic [1:0]    take;
  logic          win;
  logic          done;

  assign px   = {p1_x, p0_x};
  assign py   = {p1_y, p0_y};
  assign pwr  = {p1_wr, p0_wr};
  assign pin  = {p1_in, p0_in};
  assign req  = {p1_rd | p1_wr, p0_rd | p0_wr};
  assign done = (state == WAIT) &&
                (rdy_b || cnt == CW'(TIMEOUT - 1));
  assign clr  = done ? (owner ? 2'b10 : 2'b01) : 2'b00;
  // a slot freed at this edge may be refilled at the same edge
  assign take = req & (~pend | clr);
  assign win  = !pend[0] ||
                (pend[1] && streak == SW'(MAX_STREAK));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= '0;
      swr     <= '0;
      sin     <= '0;
      sx      <= '0;
      sy      <= '0;
      owner   <= 1'b0;
      streak  <= '0;
      cnt     <= '0;
      x_b     <= '0;
      y_b     <= '0;
      in_b    <= 1'b0;
      read_b  <= 1'b0;
      write_b <= 1'b0;
      grant   <= '0;
      p0_ack  <= 1'b0;
      p0_out  <= 1'b0;
      p0_err  <= 1'b0;
      p1_ack  <= 1'b0;
      p1_out  <= 1'b0;
      p1_err  <= 1'b0;
    end else begin
      read_b  <= 1'b0;
      write_b <= 1'b0;
      p0_ack  <= 1'b0;
      p1_ack  <= 1'b0;
      pend    <= (pend & ~clr) | take;
      for (int n = 0; n < 2; n++) begin
        if (take[n]) begin
          sx[n]  <= px[n];
          sy[n]  <= py[n];
          sin[n] <= pin[n];
          swr[n] <= pwr[n];
        end
      end
      unique case (state)
        IDLE: begin
          if (|pend) begin
            owner   <= win;
            x_b     <= sx[win];
            y_b     <= sy[win];
            in_b    <= sin[win];
            read_b  <= !swr[win];
            write_b <= swr[win];
            grant   <= win ? 2'b10 : 2'b01;
            if (!win && pend[1]) begin
              if (streak != SW'(MAX_STREAK))
                streak <= streak + SW'(1);
            end else begin
              streak <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            grant <= '0;
            state <= IDLE;
            if (owner) begin
              p1_ack <= 1'b1;
              p1_err <= !rdy_b;
              if (rdy_b && !swr[1]) p1_out <= out_b;
            end else begin
              p0_ack <= 1'b1;
              p0_err <= !rdy_b;
              if (rdy_b && !swr[0]) p0_out <= out_b;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed and random stimulus against a transaction-level
// model of the two-port framebuffer arbiter.
module tb_fb_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] p0_x, p1_x, x_b;
  logic [7:0] p0_y, p1_y, y_b;
  logic       p0_rd, p0_wr, p0_in, p0_ack, p0_out, p0_err;
  logic       p1_rd, p1_wr, p1_in, p1_ack, p1_out, p1_err;
  logic       read_b, write_b, in_b, out_b, rdy_b, busy;
  logic [1:0] grant;

  always #5 clk = ~clk;

  fb_arbiter #(.MAX_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_x(p0_x), .p0_y(p0_y), .p0_rd(p0_rd), .p0_wr(p0_wr),
    .p0_in(p0_in), .p0_ack(p0_ack), .p0_out(p0_out),
    .p0_err(p0_err),
    .p1_x(p1_x), .p1_y(p1_y), .p1_rd(p1_rd), .p1_wr(p1_wr),
    .p1_in(p1_in), .p1_ack(p1_ack), .p1_out(p1_out),
    .p1_err(p1_err),
    .x_b(x_b), .y_b(y_b), .read_b(read_b), .write_b(write_b),
    .in_b(in_b), .out_b(out_b), .rdy_b(rdy_b),
    .grant(grant), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // inputs as seen by the DUT at each rising edge
  logic s_rd[2], s_wr[2], s_in[2];
  int   s_x[2], s_y[2];
  logic s_outb, s_rdy, s_rst;

  always @(posedge clk) begin
    s_rd[0] <= p0_rd;  s_rd[1] <= p1_rd;
    s_wr[0] <= p0_wr;  s_wr[1] <= p1_wr;
    s_in[0] <= p0_in;  s_in[1] <= p1_in;
    s_x[0]  <= int'(p0_x); s_x[1] <= int'(p1_x);
    s_y[0]  <= int'(p0_y); s_y[1] <= int'(p1_y);
    s_outb  <= out_b;
    s_rdy   <= rdy_b;
    s_rst   <= rst;
  end

  // model: owner index (-1 idle) and cycles since grant
  int m_own, m_age, m_streak;
  bit m_pend[2], m_wr[2], m_in[2];
  int m_x[2], m_y[2];
  int e_x, e_y;
  bit e_in, e_rdb, e_wrb;
  bit e_ack[2], e_out[2], e_err[2];

  task automatic model_reset();
    m_own = -1; m_age = 0; m_streak = 0;
    e_x = 0; e_y = 0; e_in = 0; e_rdb = 0; e_wrb = 0;
    for (int n = 0; n < 2; n++) begin
      m_pend[n] = 0; m_wr[n] = 0; m_in[n] = 0;
      m_x[n] = 0; m_y[n] = 0;
      e_ack[n] = 0; e_out[n] = 0; e_err[n] = 0;
    end
  endtask

  task automatic model_step();
    bit clr[2];
    int w;
    clr = '{0, 0};
    e_ack[0] = 0; e_ack[1] = 0; e_rdb = 0; e_wrb = 0;
    if (m_own < 0) begin
      if (m_pend[0] || m_pend[1]) begin
        w = (m_pend[0] && !(m_pend[1] && m_streak == MAXS)) ? 0 : 1;
        if (w == 0 && m_pend[1])
          m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        else
          m_streak = 0;
        m_own = w; m_age = 0;
        e_x = m_x[w]; e_y = m_y[w]; e_in = m_in[w];
        if (m_wr[w]) e_wrb = 1; else e_rdb = 1;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (s_rdy) begin
      clr[m_own] = 1; e_ack[m_own] = 1; e_err[m_own] = 0;
      if (!m_wr[m_own]) e_out[m_own] = s_outb;
      m_own = -1;
    end else if (m_age == TMO) begin
      clr[m_own] = 1; e_ack[m_own] = 1; e_err[m_own] = 1;
      m_own = -1;
    end else begin
      m_age++;
    end
    for (int n = 0; n < 2; n++) begin
      if ((s_rd[n] || s_wr[n]) && (!m_pend[n] || clr[n])) begin
        m_pend[n] = 1; m_wr[n] = s_wr[n]; m_in[n] = s_in[n];
        m_x[n] = s_x[n]; m_y[n] = s_y[n];
      end else if (clr[n]) begin
        m_pend[n] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst || s_rst !== 1'b0) begin
      model_reset();
    end else begin
      model_step();
      chk("x_b", x_b, e_x);
      chk("y_b", y_b, e_y);
      chk("in_b", in_b, e_in);
      chk("read_b", read_b, e_rdb);
      chk("write_b", write_b, e_wrb);
      chk("grant", grant, (m_own < 0) ? 0 : (1 << m_own));
      chk("busy", busy, m_own >= 0);
      chk("p0_ack", p0_ack, e_ack[0]);
      chk("p0_out", p0_out, e_out[0]);
      chk("p0_err", p0_err, e_err[0]);
      chk("p1_ack", p1_ack, e_ack[1]);
      chk("p1_out", p1_out, e_out[1]);
      chk("p1_err", p1_err, e_err[1]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input int p, input bit rd, input bit wr,
                     input int x, input int y, input bit din);
    if (p == 0) begin
      p0_rd = rd; p0_wr = wr; p0_x = 9'(x); p0_y = 8'(y); p0_in = din;
    end else begin
      p1_rd = rd; p1_wr = wr; p1_x = 9'(x); p1_y = 8'(y); p1_in = din;
    end
    tick();
    p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0;
  endtask

  int n, n0;
  bit seen;

  initial begin
    p0_x = 0; p0_y = 0; p0_rd = 0; p0_wr = 0; p0_in = 0;
    p1_x = 0; p1_y = 0; p1_rd = 0; p1_wr = 0; p1_in = 0;
    out_b = 0; rdy_b = 1;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_pulses", {read_b, write_b, p0_ack, p1_ack}, 0);
    chk("rst_xy", {x_b, y_b}, 0);
    rst = 0;
    tick(2);

    // single p1 read, ready tied high
    out_b = 1;
    req(1, 1, 0, 5, 7, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_read_b", read_b, 1);
    chk("t1_xy", {x_b, y_b}, {9'd5, 8'd7});
    chk("t1_grant", grant, 2'b10);
    @(negedge clk);
    chk("t1_read_off", read_b, 0);
    @(negedge clk);
    chk("t1_ack", {p1_ack, p1_out, p1_err}, 3'b110);
    @(negedge clk);
    chk("t1_done", {p1_ack, grant}, 3'b000);
    tick(2);

    // simultaneous p0 write and p1 read
    p0_wr = 1; p0_x = 319; p0_y = 199; p0_in = 1;
    p1_rd = 1; p1_x = 3; p1_y = 4;
    tick();
    p0_wr = 0; p1_rd = 0; out_b = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_write_b", write_b, 1);
    chk("t2_xyin", {x_b, y_b, in_b}, {9'd319, 8'd199, 1'b1});
    chk("t2_grant", grant, 2'b01);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!(p0_ack || p1_ack) && n < 20);
      chk("t2_ack_order", {p1_ack, p0_ack}, (k == 0) ? 2'b01 : 2'b10);
    end
    tick(2);

    // starvation guard, twice to show the streak restarts
    for (int r = 0; r < 2; r++) begin
      p0_rd = 1; p0_x = 1; p1_rd = 1; p1_x = 2;
      tick();
      p1_rd = 0;
      n0 = 0; seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk);
        if (p0_ack) n0++;
        if (p1_ack) seen = 1;
      end
      chk("t3_p1_served", seen, 1);
      chk("t3_streak", n0, MAXS);
      tick();
      p0_rd = 0;
      tick(10);
    end

    // timeout
    rdy_b = 0;
    req(0, 1, 0, 10, 20, 0);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!read_b && n < 10);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!p0_ack && n < 400);
    chk("t4_timeout_cycles", n, 256);
    chk("t4_err", p0_err, 1);
    @(negedge clk);
    chk("t4_busy", busy, 0);
    tick();
    rdy_b = 1;
    tick(2);

    // async reset while waiting
    rdy_b = 0;
    req(1, 1, 0, 8, 9, 0);
    tick(5);
    #2 rst = 1;
    #1;
    chk("t5_rst_busy", {busy, grant}, 0);
    chk("t5_rst_out", {x_b, y_b, p1_out, p0_out}, 0);
    chk("t5_rst_ack", {p0_ack, p1_ack, read_b, write_b}, 0);
    tick(2);
    rst = 0; rdy_b = 1; out_b = 1;
    tick();
    req(1, 1, 0, 8, 9, 0);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!p1_ack && n < 20);
    chk("t5_recover_ack", p1_ack, 1);
    chk("t5_recover_out", p1_out, 1);
    tick(2);

    // duplicate request while in flight
    rdy_b = 0; out_b = 0;
    req(1, 1, 0, 1, 1, 0);
    tick(4);
    req(1, 1, 0, 2, 2, 0);
    tick(2);
    rdy_b = 1;
    n0 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (p1_ack) n0++;
    end
    chk("t6_single_ack", n0, 1);
    tick();

    // random traffic
    for (int k = 0; k < 4000; k++) begin
      p0_rd = ($urandom % 6) == 0;
      p0_wr = ($urandom % 10) == 0;
      p1_rd = ($urandom % 5) == 0;
      p1_wr = ($urandom % 7) == 0;
      p0_x = 9'($urandom_range(0, 511));
      p1_x = 9'($urandom_range(0, 511));
      p0_y = 8'($urandom_range(0, 255));
      p1_y = 8'($urandom_range(0, 255));
      p0_in = 1'($urandom); p1_in = 1'($urandom);
      out_b = 1'($urandom);
      rdy_b = ($urandom % 4) != 0;
      tick();
    end
    p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0; rdy_b = 1;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-pixel framebuffer port (x_b/y_b/read_b/write_b/in_b/out_b/rdy_b) between two requesters.
- Port 0 is the high-priority requester (scanout / video fetch). Port 1 is the drawing engine (fill / blit / byte access).
- Fixed priority to port 0, with a starvation guard for port 1.
- Sits between the requesters and the framebuffer. Each requester sees the same pulse/ready protocol the framebuffer exposes.

Parameters:
- MAX_STREAK, 4: maximum consecutive port-0 grants while port 1 is pending; the next grant then goes to port 1.
- TIMEOUT, 255: cycles spent in WAIT without rdy_b before the transaction is aborted with an error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- p0_x  in  9  port 0 pixel x
- p0_y  in  8  port 0 pixel y
- p0_rd  in  1  port 0 read request, one-cycle pulse
- p0_wr  in  1  port 0 write request, one-cycle pulse
- p0_in  in  1  port 0 write data
- p0_ack  out  1  port 0 completion, one-cycle pulse
- p0_out  out  1  port 0 read data, valid with p0_ack, held until next ack
- p0_err  out  1  port 0 timeout flag, valid with p0_ack
- p1_x, p1_y, p1_rd, p1_wr, p1_in, p1_ack, p1_out, p1_err: same as port 0, for port 1
- x_b  out  9  framebuffer x
- y_b  out  8  framebuffer y
- read_b  out  1  framebuffer read pulse
- write_b  out  1  framebuffer write pulse
- in_b  out  1  framebuffer write data
- out_b  in  1  framebuffer read data
- rdy_b  in  1  framebuffer ready
- grant  out  2  one-hot owner of the current transaction (00 when idle)
- busy  out  1  high when state != IDLE

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: all outputs 0, pending slots cleared, streak = 0, state = IDLE.
  - Reset mid-transaction drops it; no ack is issued.
- Request capture:
  - A rising pulse on pN_rd or pN_wr at edge E sets pending[N] and latches x, y, in and the op.
  - If rd and wr are both high, write wins.
  - A new request on a port whose slot is already pending or in flight is ignored.
  - A requester must wait for ack before issuing again.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any slot is pending, choose the winner.
  - Default winner is port 0 if pending[0], else port 1.
  - If pending[0], pending[1] and streak == MAX_STREAK, port 1 wins.
  - Drive x_b, y_b, in_b from the winner's slot. Pulse read_b or write_b for one cycle. Set grant. Go to ISSUE.
  - A request captured at edge E is first eligible for grant at edge E+1.
- ISSUE: deassert read_b/write_b, clear the timeout counter, go to WAIT.
- WAIT:
  - On rdy_b == 1 with read_b/write_b low: latch out_b into pN_out (reads only; writes leave pN_out unchanged). Pulse pN_ack, clear pending[N], set grant to 0, return to IDLE.
  - If the counter reaches TIMEOUT first: pulse pN_ack with pN_err = 1, leave pN_out unchanged, return to IDLE.
  - pN_err is 0 on normal acks.
- Minimum latency: request at edge 0, read_b high during cycle 1, WAIT from edge 2. With rdy_b high, ack rises at edge 3.
- Streak counter:
  - A port-0 grant while pending[1] increments streak (saturating at MAX_STREAK).
  - A port-0 grant with port 1 idle, or any port-1 grant, clears it.
- Simultaneous events:
  - A request on one port can be captured in the same cycle the other port is acked. It competes at the next IDLE.
  - A request arriving during the ack cycle of the same port is accepted, because the slot is cleared at that edge.
- x_b, y_b and in_b hold their values after the transaction. Only read_b/write_b are pulses.

Test Plan:
- Single read on p1, (x=5, y=7), framebuffer returns out_b=1, rdy_b tied high → read_b pulses one cycle with x_b=5, y_b=7; p1_ack one cycle at edge 3 with p1_out=1; grant=10 during the transaction.
- p0 write (x=319, y=199, in=1) and p1 read in the same cycle → p0 served first with write_b, x_b=319, y_b=199, in_b=1; p1 served immediately after; two acks in order p0 then p1.
- p0 requests back-to-back on every ack while p1 is pending, MAX_STREAK=4 → p0 granted 4 times, then p1 granted once; streak resets afterwards.
- rdy_b held low for 300 cycles, TIMEOUT=255 → ack with err=1 exactly 255 cycles after entering WAIT; busy low afterwards.
- rst asserted while in WAIT → all outputs 0 on the same cycle (asynchronous), no ack; a subsequent request completes normally.
- Duplicate p1_rd pulse while p1 is in flight → ignored; exactly one p1_ack.
